mux_word_serializer: RTL and testbench

Upstream sequencer for the 8:1 mux datapath: accepts 8-bit words over a valid/ready handshake, holds each word, and steps the mux select through all eight positions, one bit per accepted output beat. It drives the mux `in`/`sel` inputs directly and exposes the selected bit with valid/ready and last-bit framing to the downstream serial consumer. It turns the mux from a static selector into a complete parallel-to-serial stage.

---
 rtl/mux_word_serializer_pkg.sv | 15 +
 rtl/mux_word_serializer_mux.sv | 13 +
 rtl/mux_word_serializer.sv | 79 +++++++
 tb/tb_mux_word_serializer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_word_serializer_pkg.sv
// Shared constants and FSM encoding for the mux word serializer.
//   SER_W : word width fed to the 8:1 mux
//   SEL_W : mux select width
//   state_t : two-state serializer FSM (idle / sending a word)
package mux_word_serializer_pkg;

   localparam int SER_W = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

endpackage

// File: rtl/mux_word_serializer_mux.sv
// eight_one_mux: the 8:1 bit selector of the downstream datapath.
//   in  : 8-bit data word
//   sel : bit index
//   y   : in[sel]
module eight_one_mux (
   input  logic [7:0] in,
   input  logic [2:0] sel,
   output logic       y
);

   assign y = in[sel];

endmodule

// File: rtl/mux_word_serializer.sv
// mux_word_serializer: parallel-to-serial sequencer around eight_one_mux.
// Accepts 8-bit words on a valid/ready handshake, holds the word on mux_in and
// walks sel from S to E, presenting one bit per accepted output beat.
//   clk, rst_n         : clock, async active-low reset
//   in_valid/in_ready  : upstream word handshake, in_data is the word
//   flush              : synchronous abort of the word in flight
//   mux_in, sel        : held word and bit index, wired to the mux
//   ser_bit            : mux output, mux_in[sel]
//   out_valid/out_ready: downstream bit handshake, out_last marks bit E
module mux_word_serializer
   import mux_word_serializer_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SER_W-1:0] in_data,
   input  logic             flush,
   output logic [SER_W-1:0] mux_in,
   output logic [SEL_W-1:0] sel,
   output logic             ser_bit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last
);

   localparam logic [SEL_W-1:0] SEL_S = MSB_FIRST ? SEL_W'(SER_W-1) : '0;
   localparam logic [SEL_W-1:0] SEL_E = MSB_FIRST ? '0 : SEL_W'(SER_W-1);

   state_t state_q, state_d;
   logic   accept, xfer;

   assign out_valid = (state_q == ST_SEND);
   assign out_last  = out_valid & (sel == SEL_E);
   // Accepting on the last-bit transfer removes the idle bubble between words.
   assign in_ready  = ~out_valid | (out_last & out_ready & ~flush);
   assign accept    = in_valid & in_ready & ~flush;
   assign xfer      = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      if (flush)
         state_d = ST_IDLE;
      else if (accept)
         state_d = ST_SEND;
      else if (xfer && out_last)
         state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Word and index hold on flush and after the last bit; only an accept
   // reloads them, so sel never wraps past E.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mux_in <= '0;
         sel    <= '0;
      end else if (accept) begin
         mux_in <= in_data;
         sel    <= SEL_S;
      end else if (xfer && !out_last && !flush) begin
         sel <= MSB_FIRST ? sel - SEL_W'(1) : sel + SEL_W'(1);
      end
   end

   eight_one_mux u_mux (
      .in  (mux_in),
      .sel (sel),
      .y   (ser_bit)
   );

endmodule

// File: tb/tb_mux_word_serializer.sv
// Bench for mux_word_serializer: one LSB-first and one MSB-first instance,
// directed vector tables, hand sequences and random traffic against a
// beat-counting reference model.
module tb_mux_word_serializer;

   logic       clk, rst_n;
   logic       iv   [2];
   logic       ir   [2];
   logic [7:0] id   [2];
   logic       fl   [2];
   logic [7:0] mi   [2];
   logic [2:0] sl   [2];
   logic       sb   [2];
   logic       ov   [2];
   logic       ordy [2];
   logic       olst [2];

   int n_chk, n_pass;

   mux_word_serializer #(.MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .in_data(id[0]), .flush(fl[0]), .mux_in(mi[0]), .sel(sl[0]),
      .ser_bit(sb[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_last(olst[0])
   );

   mux_word_serializer #(.MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .in_data(id[1]), .flush(fl[1]), .mux_in(mi[1]), .sel(sl[1]),
      .ser_bit(sb[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_last(olst[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   // Reference model: a word is in flight for 8 beats; m_k counts beats done.
   // Instance 1 sends bit 7-k on beat k, instance 0 sends bit k.
   logic       m_busy [2];
   logic       m_fresh[2];
   logic [2:0] m_k    [2];
   logic [7:0] m_word [2];

   function automatic logic f_rdy(int i);
      return !m_busy[i] || (m_k[i] == 3'd7 && ordy[i] && !fl[i]);
   endfunction

   function automatic logic [2:0] f_sel(int i);
      if (m_fresh[i]) return 3'd0;
      return (i == 1) ? 3'd7 - m_k[i] : m_k[i];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_busy[i] <= 1'b0; m_fresh[i] <= 1'b1;
            m_k[i] <= 3'd0;    m_word[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (fl[i])
               m_busy[i] <= 1'b0;
            else if (iv[i] && f_rdy(i)) begin
               m_busy[i] <= 1'b1; m_fresh[i] <= 1'b0;
               m_k[i] <= 3'd0;    m_word[i] <= id[i];
            end else if (m_busy[i] && ordy[i]) begin
               if (m_k[i] == 3'd7) m_busy[i] <= 1'b0;
               else m_k[i] <= m_k[i] + 3'd1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("m%0d out_valid", i), 32'(ov[i]), 32'(m_busy[i]));
            chk($sformatf("m%0d in_ready", i), 32'(ir[i]), 32'(f_rdy(i)));
            chk($sformatf("m%0d sel", i), 32'(sl[i]), 32'(f_sel(i)));
            chk($sformatf("m%0d mux_in", i), 32'(mi[i]), 32'(m_word[i]));
            chk($sformatf("m%0d ser_bit", i), 32'(sb[i]), 32'(m_word[i][f_sel(i)]));
            chk($sformatf("m%0d out_last", i), 32'(olst[i]),
                32'(m_busy[i] && m_k[i] == 3'd7));
         end
      end
   end

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       r;
      logic       f;
      logic       e_vld;
      logic       e_rdy;
      logic [2:0] e_sel;
      logic       e_bit;
      logic       e_last;
   } vec_t;

   vec_t t0[10], t1[10];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int i, input logic v, input logic [7:0] d,
                      input logic r, input logic f);
      iv[i] = v; id[i] = d; ordy[i] = r; fl[i] = f;
   endtask

   int vcnt, rcnt;

   initial begin
      n_chk = 0; n_pass = 0;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) drv(i, 1'b0, 8'h00, 1'b0, 1'b0);

      // LSB-first 10101010: bits 0,1,0,1,... on sel 0..7
      t0[0] = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
      t0[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
      t0[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
      t0[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
      t0[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0};
      t0[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
      t0[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0};
      t0[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0};
      t0[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1};
      t0[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0};
      // MSB-first 11001010: bits 1,1,0,0,1,0,1,0 on sel 7..0
      t1[0] = '{1'b1, 8'hCA, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
      t1[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 1'b1, 1'b0};
      t1[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0};
      t1[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0};
      t1[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
      t1[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0};
      t1[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
      t1[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
      t1[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1};
      t1[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};

      // Reset state
      #3;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst%0d out_valid", i), 32'(ov[i]), 32'd0);
         chk($sformatf("rst%0d in_ready", i), 32'(ir[i]), 32'd1);
         chk($sformatf("rst%0d sel", i), 32'(sl[i]), 32'd0);
         chk($sformatf("rst%0d mux_in", i), 32'(mi[i]), 32'd0);
         chk($sformatf("rst%0d out_last", i), 32'(olst[i]), 32'd0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed word tables, both instances in lockstep
      for (int n = 0; n < 10; n++) begin
         cyc();
         drv(0, t0[n].v, t0[n].d, t0[n].r, t0[n].f);
         drv(1, t1[n].v, t1[n].d, t1[n].r, t1[n].f);
         @(negedge clk);
         chk($sformatf("tbl0[%0d] vld", n), 32'(ov[0]), 32'(t0[n].e_vld));
         chk($sformatf("tbl0[%0d] rdy", n), 32'(ir[0]), 32'(t0[n].e_rdy));
         chk($sformatf("tbl0[%0d] sel", n), 32'(sl[0]), 32'(t0[n].e_sel));
         chk($sformatf("tbl0[%0d] bit", n), 32'(sb[0]), 32'(t0[n].e_bit));
         chk($sformatf("tbl0[%0d] last", n), 32'(olst[0]), 32'(t0[n].e_last));
         chk($sformatf("tbl1[%0d] vld", n), 32'(ov[1]), 32'(t1[n].e_vld));
         chk($sformatf("tbl1[%0d] rdy", n), 32'(ir[1]), 32'(t1[n].e_rdy));
         chk($sformatf("tbl1[%0d] sel", n), 32'(sl[1]), 32'(t1[n].e_sel));
         chk($sformatf("tbl1[%0d] bit", n), 32'(sb[1]), 32'(t1[n].e_bit));
         chk($sformatf("tbl1[%0d] last", n), 32'(olst[1]), 32'(t1[n].e_last));
      end

      // Backpressure: stall 3 cycles at sel=4 of 8'hF0
      cyc(); drv(0, 1'b1, 8'hF0, 1'b1, 1'b0);
      cyc(); drv(0, 1'b0, 8'h00, 1'b1, 1'b0);
      repeat (4) cyc();
      drv(0, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall sel", 32'(sl[0]), 32'd4);
         chk("stall bit", 32'(sb[0]), 32'd1);
         chk("stall vld", 32'(ov[0]), 32'd1);
         cyc();
      end
      drv(0, 1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk); chk("resume sel4", 32'(sl[0]), 32'd4);
      cyc();
      @(negedge clk); chk("resume sel5", 32'(sl[0]), 32'd5);
      repeat (4) cyc();

      // Back-to-back A5 then 3C, accept on last bit
      drv(0, 1'b1, 8'hA5, 1'b1, 1'b0);
      cyc(); drv(0, 1'b0, 8'h00, 1'b1, 1'b0);
      vcnt = 0; rcnt = 0;
      for (int b = 0; b < 16; b++) begin
         if (b == 7) drv(0, 1'b1, 8'h3C, 1'b1, 1'b0);
         else        drv(0, 1'b0, 8'h00, 1'b1, 1'b0);
         @(negedge clk);
         if (ov[0]) vcnt++;
         if (ir[0]) rcnt++;
         if (b == 7) chk("b2b rdy at last", 32'(ir[0]), 32'd1);
         if (b == 8) chk("b2b reload sel", 32'(sl[0]), 32'd0);
         cyc();
      end
      chk("b2b valid beats", 32'(vcnt), 32'd16);
      chk("b2b ready pulses", 32'(rcnt), 32'd2);
      @(negedge clk); chk("b2b idle after", 32'(ov[0]), 32'd0);

      // Flush at sel=3 of 8'hFF with in_valid high
      cyc(); drv(0, 1'b1, 8'hFF, 1'b1, 1'b0);
      cyc(); drv(0, 1'b0, 8'h00, 1'b1, 1'b0);
      repeat (3) cyc();
      drv(0, 1'b1, 8'h00, 1'b1, 1'b1);
      @(negedge clk);
      chk("flush rdy", 32'(ir[0]), 32'd0);
      chk("flush sel", 32'(sl[0]), 32'd3);
      cyc(); drv(0, 1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      chk("flush vld", 32'(ov[0]), 32'd0);
      chk("flush no accept", 32'(mi[0]), 32'hFF);
      cyc(); drv(0, 1'b1, 8'h81, 1'b1, 1'b0);
      cyc(); drv(0, 1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      chk("post-flush sel", 32'(sl[0]), 32'd0);
      chk("post-flush bit", 32'(sb[0]), 32'd1);
      repeat (8) cyc();

      // Reset mid-word at sel=5
      drv(0, 1'b1, 8'h5A, 1'b1, 1'b0); drv(1, 1'b1, 8'h5A, 1'b1, 1'b0);
      cyc();
      drv(0, 1'b0, 8'h00, 1'b1, 1'b0); drv(1, 1'b0, 8'h00, 1'b1, 1'b0);
      repeat (5) cyc();
      chk("pre-rst sel", 32'(sl[0]), 32'd5);
      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("midrst%0d vld", i), 32'(ov[i]), 32'd0);
         chk($sformatf("midrst%0d sel", i), 32'(sl[i]), 32'd0);
         chk($sformatf("midrst%0d mux_in", i), 32'(mi[i]), 32'd0);
      end
      cyc(); #1 rst_n = 1'b1;
      cyc(); drv(0, 1'b1, 8'h3E, 1'b1, 1'b0);
      cyc(); drv(0, 1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      chk("post-rst sel", 32'(sl[0]), 32'd0);
      chk("post-rst vld", 32'(ov[0]), 32'd1);
      cyc();
      @(negedge clk);
      chk("post-rst bit1", 32'(sb[0]), 32'd1);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         cyc();
         for (int i = 0; i < 2; i++)
            drv(i, 1'(($urandom & 32'd1) != 0), 8'($urandom),
                1'(($urandom % 4) != 0), 1'(($urandom % 16) == 0));
      end
      cyc();
      for (int i = 0; i < 2; i++) drv(i, 1'b0, 8'h00, 1'b1, 1'b0);
      repeat (10) cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
